// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, R-type functs, ALU op codes and the
// bit layout of the EX control nibble, plus the opcode/funct decoder.
package mips_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_XOR     = 4'b0100,
    ALU_NOR     = 4'b0101,
    ALU_SUB     = 4'b0110,
    ALU_SLT     = 4'b0111,
    ALU_XORI    = 4'b1001,
    ALU_ILLEGAL = 4'b1111
  } aluOp_t;

  localparam int CTRL_REG_WRITE = 3;
  localparam int CTRL_MEM_READ  = 2;
  localparam int CTRL_MEM_WRITE = 1;
  localparam int CTRL_BRANCH    = 0;

  localparam logic [3:0] CTRL_ALU    = 4'(1 << CTRL_REG_WRITE);
  localparam logic [3:0] CTRL_LOAD   = 4'((1 << CTRL_REG_WRITE) | (1 << CTRL_MEM_READ));
  localparam logic [3:0] CTRL_STORE  = 4'(1 << CTRL_MEM_WRITE);
  localparam logic [3:0] CTRL_BRANCH_ONLY = 4'(1 << CTRL_BRANCH);

  typedef struct packed {
    logic       illegal;
    aluOp_t     op;
    logic [3:0] ctrl;
    logic       useImm;
    logic       signExt;
    logic       destIsRd;
  } decode_t;

  function automatic decode_t decodeInstr(input logic [5:0] opcode, input logic [5:0] funct);
    decode_t d;
    d = '{illegal: 1'b0, op: ALU_AND, ctrl: 4'b0000, useImm: 1'b0, signExt: 1'b1, destIsRd: 1'b0};
    case (opcode)
      OPC_RTYPE: begin
        d.ctrl     = CTRL_ALU;
        d.destIsRd = 1'b1;
        case (funct)
          FN_AND:          d.op = ALU_AND;
          FN_OR:           d.op = ALU_OR;
          FN_ADD, FN_ADDU: d.op = ALU_ADD;
          FN_XOR:          d.op = ALU_XOR;
          FN_NOR:          d.op = ALU_NOR;
          FN_SUB, FN_SUBU: d.op = ALU_SUB;
          FN_SLT:          d.op = ALU_SLT;
          default:         d.illegal = 1'b1;
        endcase
      end
      OPC_ADDI, OPC_ADDIU: begin d.op = ALU_ADD; d.ctrl = CTRL_ALU; d.useImm = 1'b1; end
      OPC_SLTI: begin d.op = ALU_SLT; d.ctrl = CTRL_ALU; d.useImm = 1'b1; end
      OPC_ANDI: begin d.op = ALU_AND; d.ctrl = CTRL_ALU; d.useImm = 1'b1; d.signExt = 1'b0; end
      OPC_ORI:  begin d.op = ALU_OR; d.ctrl = CTRL_ALU; d.useImm = 1'b1; d.signExt = 1'b0; end
      OPC_XORI: begin d.op = ALU_XORI; d.ctrl = CTRL_ALU; d.useImm = 1'b1; d.signExt = 1'b0; end
      OPC_LW:   begin d.op = ALU_ADD; d.ctrl = CTRL_LOAD; d.useImm = 1'b1; end
      OPC_SW:   begin d.op = ALU_ADD; d.ctrl = CTRL_STORE; d.useImm = 1'b1; end
      OPC_BEQ:  begin d.op = ALU_SUB; d.ctrl = CTRL_BRANCH_ONLY; end
      default:  d.illegal = 1'b1;
    endcase
    if (d.illegal) begin
      d.op     = ALU_ILLEGAL;
      d.ctrl   = 4'b0000;
      d.useImm = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand bypass: picks the youngest in-flight writer of a source register,
// falling back to the value latched from the register file.
module fwd_unit #(
  parameter int ANCHO_BUS = 32
) (
  input  logic [4:0]           src_i,
  input  logic [ANCHO_BUS-1:0] regData_i,
  input  logic                 exmemRegWrite_i,
  input  logic [4:0]           exmemDest_i,
  input  logic [ANCHO_BUS-1:0] exmemResult_i,
  input  logic                 memwbRegWrite_i,
  input  logic [4:0]           memwbDest_i,
  input  logic [ANCHO_BUS-1:0] memwbResult_i,
  output logic [ANCHO_BUS-1:0] data_o
);

  logic srcNonZero;
  assign srcNonZero = (src_i != 5'd0);

  always_comb begin
    data_o = regData_i;
    if (exmemRegWrite_i && srcNonZero && (exmemDest_i == src_i)) begin
      data_o = exmemResult_i;
    end else if (memwbRegWrite_i && srcNonZero && (memwbDest_i == src_i)) begin
      data_o = memwbResult_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the MIPS core: decodes the instruction, latches
// operands, forwards from later stages and detects load-use hazards.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int ANCHO_BUS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [31:0]          id_instr,
  input  logic [ANCHO_BUS-1:0] id_rs_data,
  input  logic [ANCHO_BUS-1:0] id_rt_data,
  input  logic                 exmem_reg_write,
  input  logic [4:0]           exmem_dest,
  input  logic [ANCHO_BUS-1:0] exmem_result,
  input  logic                 memwb_reg_write,
  input  logic [4:0]           memwb_dest,
  input  logic [ANCHO_BUS-1:0] memwb_result,
  output logic [ANCHO_BUS-1:0] alu_data1,
  output logic [ANCHO_BUS-1:0] alu_data2,
  output logic [3:0]           alu_operation,
  output logic [ANCHO_BUS-1:0] ex_store_data,
  output logic [4:0]           ex_dest,
  output logic [3:0]           ex_ctrl,
  output logic                 ex_valid,
  output logic                 ex_illegal,
  output logic                 load_use_stall
);

  typedef struct packed {
    logic                 valid;
    logic                 illegal;
    logic                 useImm;
    logic [3:0]           op;
    logic [3:0]           ctrl;
    logic [4:0]           dest;
    logic [4:0]           rsNum;
    logic [4:0]           rtNum;
    logic [ANCHO_BUS-1:0] rsData;
    logic [ANCHO_BUS-1:0] rtData;
    logic [ANCHO_BUS-1:0] imm;
  } stage_t;

  stage_t  stage_q, stage_d, loadVal;
  decode_t dec;
  logic [ANCHO_BUS-1:0] rsFwd, rtFwd;

  // An all-zero stage is the bubble, so flush, hazard and reset share it.
  always_comb begin
    dec             = decodeInstr(id_instr[31:26], id_instr[5:0]);
    loadVal         = '0;
    loadVal.valid   = 1'b1;
    loadVal.illegal = dec.illegal;
    loadVal.useImm  = dec.useImm;
    loadVal.op      = dec.op;
    loadVal.ctrl    = dec.ctrl;
    loadVal.dest    = !dec.ctrl[CTRL_REG_WRITE] ? 5'd0 :
                      (dec.destIsRd ? id_instr[15:11] : id_instr[20:16]);
    loadVal.rsNum   = id_instr[25:21];
    loadVal.rtNum   = id_instr[20:16];
    loadVal.rsData  = id_rs_data;
    loadVal.rtData  = id_rt_data;
    loadVal.imm     = dec.signExt ? {{(ANCHO_BUS-16){id_instr[15]}}, id_instr[15:0]}
                                  : {{(ANCHO_BUS-16){1'b0}}, id_instr[15:0]};
    if (flush) begin
      stage_d = '0;
    end else if (stall) begin
      stage_d = stage_q;
    end else if (load_use_stall || !id_valid) begin
      stage_d = '0;
    end else begin
      stage_d = loadVal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  fwd_unit #(.ANCHO_BUS(ANCHO_BUS)) uFwdRs (
    .src_i(stage_q.rsNum), .regData_i(stage_q.rsData),
    .exmemRegWrite_i(exmem_reg_write), .exmemDest_i(exmem_dest), .exmemResult_i(exmem_result),
    .memwbRegWrite_i(memwb_reg_write), .memwbDest_i(memwb_dest), .memwbResult_i(memwb_result),
    .data_o(rsFwd)
  );

  fwd_unit #(.ANCHO_BUS(ANCHO_BUS)) uFwdRt (
    .src_i(stage_q.rtNum), .regData_i(stage_q.rtData),
    .exmemRegWrite_i(exmem_reg_write), .exmemDest_i(exmem_dest), .exmemResult_i(exmem_result),
    .memwbRegWrite_i(memwb_reg_write), .memwbDest_i(memwb_dest), .memwbResult_i(memwb_result),
    .data_o(rtFwd)
  );

  assign alu_data1     = rsFwd;
  assign ex_store_data = rtFwd;
  assign alu_data2     = stage_q.useImm ? stage_q.imm : rtFwd;
  assign alu_operation = stage_q.valid ? stage_q.op : 4'b0000;
  assign ex_ctrl       = stage_q.valid ? stage_q.ctrl : 4'b0000;
  assign ex_illegal    = stage_q.valid & stage_q.illegal;
  assign ex_valid      = stage_q.valid;
  assign ex_dest       = stage_q.dest;

  assign load_use_stall = stage_q.valid & stage_q.ctrl[CTRL_MEM_READ] & (stage_q.dest != 5'd0) &
                          id_valid & ((stage_q.dest == id_instr[25:21]) |
                                      (stage_q.dest == id_instr[20:16]));

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: ANCHO_BUS, 32, datapath width in bits.
REQ-002 The block SHALL have exactly these ports (name  direction  width  meaning):
  clk  input  1  rising-edge clock
  rst  input  1  reset rst, synchronous, active-high
  stall  input  1  hold all stage registers
  flush  input  1  replace next stage contents with bubble
  id_valid  input  1  id_instr is a real instruction
  id_instr  input  32  MIPS instruction word from decode
  id_rs_data  input  ANCHO_BUS  register-file value for instr[25:21]
  id_rt_data  input  ANCHO_BUS  register-file value for instr[20:16]
  exmem_reg_write  input  1  EX/MEM instruction writes a register
  exmem_dest  input  5  EX/MEM destination register
  exmem_result  input  ANCHO_BUS  EX/MEM ALU result
  memwb_reg_write  input  1  MEM/WB instruction writes a register
  memwb_dest  input  5  MEM/WB destination register
  memwb_result  input  ANCHO_BUS  MEM/WB writeback value
  alu_data1  output  ANCHO_BUS  ALU operand 1, forwarded rs
  alu_data2  output  ANCHO_BUS  ALU operand 2, immediate or forwarded rt
  alu_operation  output  4  ALU op code
  ex_store_data  output  ANCHO_BUS  forwarded rt, used for SW
  ex_dest  output  5  destination register
  ex_ctrl  output  4  {reg_write, mem_read, mem_write, branch}
  ex_valid  output  1  EX slot holds a real instruction
  ex_illegal  output  1  unsupported opcode/funct latched
  load_use_stall  output  1  upstream must hold IF/ID this cycle

Function
REQ-003 Stage registers SHALL capture on rising clk: rs/rt data, extended immediate, rs/rt/dest numbers, op, ctrl, valid, illegal; priority rst > flush > stall (hold) > load_use_stall (bubble) > load.
REQ-004 A bubble SHALL be ex_valid=0, ex_ctrl=0000, ex_illegal=0, alu_operation=0000; ex_ctrl, ex_illegal and alu_operation SHALL read 0 whenever ex_valid=0.
REQ-005 Decode, R-type (opcode 0), funct to op: 0x24 AND 0000; 0x25 OR 0001; 0x20/0x21 ADD 0010; 0x26 XOR 0100; 0x27 NOR 0101; 0x22/0x23 SUB 0110; 0x2A SLT 0111; ctrl=1000; dest=rd.
REQ-006 Decode, I-type, opcode to op: 0x08/0x09 ADDI 0010 sign-ext; 0x0A SLTI 0111 sign-ext; 0x0C ANDI 0000, 0x0D ORI 0001, 0x0E XORI 1001, all zero-ext; ctrl=1000, dest=rt.
REQ-007 Memory/branch decode: 0x23 LW op 0010, ctrl 1100, dest rt; 0x2B SW op 0010, ctrl 0010; 0x04 BEQ op 0110, ctrl 0001, alu_data2=rt; all sign-ext.
REQ-008 Any other opcode/funct SHALL latch ex_illegal=1, ex_ctrl=0000, op 1111, with ex_valid=1.
REQ-009 Forwarding SHALL be combinational per operand: EX/MEM if exmem_reg_write and exmem_dest==src and src!=0, else MEM/WB under the same rule, else the latched register value; EX/MEM wins when both match.
REQ-010 alu_data2 SHALL be the extended immediate for I-type ALU ops, LW and SW, and forwarded rt otherwise; ex_store_data SHALL always be forwarded rt.
REQ-011 load_use_stall SHALL be combinational and equal ex_valid & ex_ctrl[2] & ex_dest!=0 & id_valid & (ex_dest==id_instr[25:21] | ex_dest==id_instr[20:16]).
REQ-012 Latency SHALL be one cycle from id_instr to EX outputs; register 0 SHALL never be forwarded.

Reset
REQ-013 On rst=1 at a clk edge, all stage registers SHALL clear to 0, giving a bubble, alu_data1/alu_data2/ex_store_data=0 absent forwarding, and load_use_stall=0; mid-operation reset SHALL discard the held instruction.

Structure
REQ-014 Shared package mips_pkg SHALL hold the opcode/funct constants, the ALU op codes and the ex_ctrl bit positions.
REQ-015 Sub-module fwd_unit (one instance per operand) SHALL implement REQ-009.

Verification
REQ-016 rst=1 for one cycle -> ex_valid=0, ex_ctrl=0000, alu_operation=0000, load_use_stall=0.
REQ-017 0x00221820 (ADD r3,r1,r2), rs=5, rt=7 -> next cycle alu_data1=5, alu_data2=7, op 0010, ex_dest=3, ex_ctrl=1000.
REQ-018 EX rs=r1, exmem 1/1/0xAA, memwb 1/1/0xBB -> alu_data1=0xAA; exmem_dest=0 -> 0xBB; both to r0 -> register value.
REQ-019 0x8C240000 (LW r4,0(r1)) then ADD r5,r4,r4 -> load_use_stall=1 for one cycle, then bubble (ex_valid=0), then ADD enters.
REQ-020 0x2022FFFF (ADDI) -> alu_data2=0xFFFFFFFF, op 0010; 0x3422FFFF (ORI) -> alu_data2=0x0000FFFF, op 0001.
REQ-021 stall=1 -> outputs held; stall=1 with flush=1 -> bubble; R-type funct 0x3F -> ex_illegal=1, op 1111.
